// File: rtl/param_burst_fetcher_if.sv
// Avalon-MM burst read channel between a read master (fetcher modport) and an SDRAM read slave.
interface sdram_read_intf #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 6
);
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               read;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport fetcher (
    output address, burstcount, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/param_burst_fetcher.sv
// Burst read master: splits one fetch command into credit-limited Avalon-MM bursts and
// streams the returned beats to the parameter consumer through a beat FIFO.
module param_burst_fetcher #(
  parameter int SDRAM_DATA_W = 128,
  parameter int SDRAM_ADDR_W = 32,
  parameter int MAX_BURST    = 32,
  parameter int FIFO_DEPTH   = 64,
  parameter int LEN_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [SDRAM_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]        cmd_beats,
  sdram_read_intf.fetcher         sdram,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SDRAM_DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_dbg
);
  localparam int BURST_W    = $clog2(MAX_BURST) + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int SUM_W      = CNT_W + 2;
  localparam int BEAT_BYTES = SDRAM_DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic [SDRAM_ADDR_W-1:0] next_addr;
  logic [SDRAM_ADDR_W-1:0] rd_addr;
  logic [BURST_W-1:0]      rd_len;
  logic                    rd_req;
  logic [LEN_W-1:0]        issue_rem;
  logic [LEN_W-1:0]        deliver_rem;
  logic [CNT_W-1:0]        occupancy;
  logic [CNT_W-1:0]        outstanding;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [SDRAM_DATA_W-1:0] mem [FIFO_DEPTH];

  logic                    push;
  logic                    pop;
  logic                    accept;
  logic [BURST_W-1:0]      acc_len;
  logic [LEN_W-1:0]        rem_after;
  logic [SDRAM_ADDR_W-1:0] addr_after;
  logic [BURST_W-1:0]      blen_next;
  logic [SUM_W-1:0]        committed;
  logic                    credit_ok;

  // Handshakes: a burst transfers when read=1 and waitrequest=0; a beat is popped when
  // out_valid=1 and out_ready=1; a command is taken when cmd_valid=1 and cmd_ready=1.
  assign sdram.read       = rd_req;
  assign sdram.address    = rd_addr;
  assign sdram.burstcount = rd_len;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign state_dbg = state;
  assign out_valid = (occupancy != '0);
  assign out_data  = mem[rd_ptr];
  assign out_last  = out_valid && (deliver_rem == LEN_W'(1));

  // Beats arriving with nothing outstanding are stale (e.g. from before a reset) and dropped.
  assign push   = sdram.readdatavalid && (outstanding != '0);
  assign pop    = out_valid && out_ready;
  assign accept = rd_req && !sdram.waitrequest;

  // The next burst is sized and credit-checked against the state as it will be after
  // any burst accepted this cycle, so read can stay high for back-to-back bursts.
  always_comb begin
    acc_len    = accept ? rd_len : '0;
    rem_after  = issue_rem - LEN_W'(acc_len);
    addr_after = next_addr + SDRAM_ADDR_W'(acc_len) * SDRAM_ADDR_W'(BEAT_BYTES);
    blen_next  = (rem_after >= LEN_W'(MAX_BURST)) ? BURST_W'(MAX_BURST) : BURST_W'(rem_after);
    committed  = SUM_W'(occupancy) + SUM_W'(outstanding) + SUM_W'(acc_len);
    credit_ok  = (committed + SUM_W'(blen_next)) <= SUM_W'(FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sdram.readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      next_addr   <= '0;
      rd_addr     <= '0;
      rd_len      <= '0;
      rd_req      <= 1'b0;
      issue_rem   <= '0;
      deliver_rem <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        deliver_rem <= deliver_rem - LEN_W'(1);
      end

      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
      outstanding <= outstanding + CNT_W'(acc_len) - CNT_W'(push);

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            next_addr   <= cmd_addr;
            issue_rem   <= cmd_beats;
            deliver_rem <= cmd_beats;
            if (cmd_beats == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // A stalled burst keeps read, address and burstcount untouched.
          if (!(rd_req && sdram.waitrequest)) begin
            next_addr <= addr_after;
            issue_rem <= rem_after;
            if (rem_after == '0) begin
              rd_req <= 1'b0;
              state  <= S_DRAIN;
            end else if (credit_ok) begin
              rd_req  <= 1'b1;
              rd_addr <= addr_after;
              rd_len  <= blen_next;
            end else begin
              rd_req <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (deliver_rem == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (occupancy == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_param_burst_fetcher.sv
// Directed bench for param_burst_fetcher: Avalon slave model, in-order beat scoreboard,
// and burst log checks for splitting, backpressure, waitrequest stall, zero length and reset.
module tb_param_burst_fetcher;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int BW = 6;
  localparam int EW = DW + 1;
  localparam int CW = 160;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_beats = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  sdram_read_intf #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) sd ();

  param_burst_fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_beats (cmd_beats),
    .sdram     (sd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h0000_0010, a};
  endfunction

  // ---------------- Avalon slave model ----------------
  logic [AW-1:0] rsp_q[$];
  logic [AW-1:0] acc_addr_q[$];
  logic [BW-1:0] acc_len_q[$];
  int            acc_wait_q[$];
  int            burst_idx = 0;
  int            stall_target = -1;
  int            stall_len = 0;
  int            stall_done = 0;
  int            cur_wait = 0;
  int            read_cycles = 0;
  int            issued = 0;
  bit            unstable = 0;
  bit            rsp_hold = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [BW-1:0] prev_len = '0;

  initial begin
    sd.waitrequest   = 1'b0;
    sd.readdatavalid = 1'b0;
    sd.readdata      = '0;
    forever begin
      @(negedge clk);
      if (!rsp_hold && rsp_q.size() > 0) begin
        sd.readdatavalid = 1'b1;
        sd.readdata      = beat_data(rsp_q.pop_front());
      end else begin
        sd.readdatavalid = 1'b0;
      end
      if (sd.read) begin
        read_cycles++;
        cur_wait++;
        if (cur_wait > 1 && (sd.address !== prev_addr || sd.burstcount !== prev_len)) unstable = 1;
        prev_addr = sd.address;
        prev_len  = sd.burstcount;
        if (burst_idx == stall_target && stall_done < stall_len) begin
          sd.waitrequest = 1'b1;
          stall_done++;
        end else begin
          sd.waitrequest = 1'b0;
          acc_addr_q.push_back(sd.address);
          acc_len_q.push_back(sd.burstcount);
          acc_wait_q.push_back(cur_wait);
          for (int i = 0; i < int'(sd.burstcount); i++) rsp_q.push_back(sd.address + AW'(i * 16));
          issued += int'(sd.burstcount);
          burst_idx++;
          cur_wait = 0;
        end
      end else begin
        sd.waitrequest = 1'b0;
        cur_wait = 0;
      end
    end
  end

  // ---------------- scoreboard / output monitor ----------------
  logic [EW-1:0] exp_q[$];
  int done_cnt = 0;
  int valid_cycles = 0;
  int popped = 0;
  int max_inflight = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) valid_cycles++;
        if (done) begin
          done_cnt++;
          check("busy_low_at_done", busy, 0);
        end
        if (out_valid && out_ready) begin
          popped++;
          if (exp_q.size() == 0) check("unexpected_beat", CW'(exp_q.size()), CW'(1));
          else check("beat", {out_last, out_data}, exp_q.pop_front());
        end
        if (issued - popped > max_inflight) max_inflight = issued - popped;
      end
    end
  end

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic send_cmd(input logic [AW-1:0] a, input int beats);
    int t;
    t = 0;
    cmd_addr  = a;
    cmd_beats = LW'(beats);
    cmd_valid = 1'b1;
    for (int i = 0; i < beats; i++) exp_q.push_back({(i == beats - 1), beat_data(a + AW'(i * 16))});
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 50);
    check("cmd_accepted", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, CW'(done_cnt - start), CW'(1));
    check({tag, "_all_beats"}, CW'(exp_q.size()), CW'(0));
  endtask

  task automatic check_burst(input string tag, input logic [AW-1:0] a, input int len, input int waits);
    check({tag, "_present"}, CW'(acc_addr_q.size() != 0), CW'(1));
    if (acc_addr_q.size() != 0) begin
      check({tag, "_addr"}, acc_addr_q.pop_front(), a);
      check({tag, "_len"}, acc_len_q.pop_front(), len);
      check({tag, "_cycles"}, acc_wait_q.pop_front(), waits);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  int rc;
  int v0;
  int iss0;

  initial begin
    rst = 1'b1;
    cycles(3);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_read", sd.read, 0);
    check("rst_address", sd.address, 0);
    check("rst_burstcount", sd.burstcount, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    #1;
    check("first_cycle_cmd_ready", cmd_ready, 1);
    check("first_cycle_state", state_dbg, 0);
    cycles(1);

    // single short command
    out_ready = 1'b1;
    send_cmd(32'h0000_1000, 4);
    check("t1_busy", busy, 1);
    wait_done("t1_done", 200);
    check_burst("t1_b0", 32'h0000_1000, 4, 1);

    // burst splitting
    send_cmd(32'h0000_2000, 70);
    wait_done("t2_done", 600);
    check_burst("t2_b0", 32'h0000_2000, 32, 1);
    check_burst("t2_b1", 32'h0000_2200, 32, 1);
    check_burst("t2_b2", 32'h0000_2400, 6, 1);

    // waitrequest stall on the second burst
    stall_target = burst_idx + 1;
    stall_len    = 5;
    stall_done   = 0;
    unstable     = 0;
    send_cmd(32'h0000_3000, 64);
    wait_done("t3_done", 600);
    check_burst("t3_b0", 32'h0000_3000, 32, 1);
    check_burst("t3_b1", 32'h0000_3200, 32, 6);
    check("t3_stall_stable", unstable, 0);
    stall_target = -1;

    // backpressure
    out_ready = 1'b0;
    iss0 = issued;
    send_cmd(32'h0001_0000, 200);
    cycles(90);
    check("t4_issued_held", CW'(issued - iss0), CW'(64));
    check("t4_read_low", sd.read, 0);
    check("t4_out_valid", out_valid, 1);
    check("t4_out_last", out_last, 0);
    check("t4_busy", busy, 1);
    out_ready = 1'b1;
    wait_done("t4_done", 2000);
    for (int k = 0; k < 6; k++) check_burst($sformatf("t4_b%0d", k), 32'h0001_0000 + AW'(k * 32'h200), 32, 1);
    check_burst("t4_b6", 32'h0001_0C00, 8, 1);
    check("t4_issued_total", CW'(issued - iss0), CW'(200));
    check("max_inflight_le_depth", CW'(max_inflight <= 64), CW'(1));

    // zero length
    rc = read_cycles;
    send_cmd(32'h0000_5000, 0);
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    cycles(1);
    check("t5_done_one_cycle", done, 0);
    cycles(5);
    check("t5_no_read", CW'(read_cycles - rc), CW'(0));

    // reset with 20 beats outstanding
    rsp_hold = 1'b1;
    send_cmd(32'h0000_6000, 20);
    cycles(10);
    check_burst("t6_b0", 32'h0000_6000, 20, 1);
    rst = 1'b1;
    cycles(1);
    check("t6_rst_read", sd.read, 0);
    check("t6_rst_address", sd.address, 0);
    check("t6_rst_burstcount", sd.burstcount, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_cmd_ready", cmd_ready, 0);
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
    issued = popped;
    #1;
    check("t6_cmd_ready_after", cmd_ready, 1);
    v0 = valid_cycles;
    rsp_hold = 1'b0;
    cycles(30);
    check("t6_late_beats_dropped", CW'(valid_cycles - v0), CW'(0));
    send_cmd(32'h0000_7000, 8);
    wait_done("t6_new_done", 200);
    check_burst("t6_new_b0", 32'h0000_7000, 8, 1);
    check("no_extra_bursts", CW'(acc_addr_q.size()), CW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/param_burst_fetcher.md
Name: param_burst_fetcher

Overview:
- Avalon-MM burst read master that drives the `sdram_read_intf` `fetcher` modport.
- Turns one fetch command (byte base address, beat count) into a sequence of bursts of at most MAX_BURST beats each.
- Buffers returned beats in an internal FIFO and streams them to the parameter consumer over valid/ready with a last marker.
- Sits between the NPU control sequencer (upstream) and the SDRAM read slave (downstream).

Parameters:
- SDRAM_DATA_W, 128, beat width in bits; must match the interface.
- SDRAM_ADDR_W, 32, byte address width; must match the interface.
- MAX_BURST, 32, maximum beats per burst; power of 2, at most FIFO_DEPTH.
- FIFO_DEPTH, 64, beat buffer depth; power of 2.
- LEN_W, 16, width of the beat-count field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  fetch command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  SDRAM_ADDR_W  byte base address, beat aligned.
- cmd_beats  in  LEN_W  total beats to fetch.
- sdram  modport  sdram_read_intf.fetcher  address, burstcount, read (out); waitrequest, readdata, readdatavalid (in).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept.
- out_data  out  SDRAM_DATA_W  FIFO head beat.
- out_last  out  1  head beat is the final beat of the command.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after reset. read=0, address=0, burstcount=0, out_valid=0, out_last=0, busy=0, done=0.
- Reset clears FIFO, counters and credits. readdatavalid beats arriving with zero outstanding beats are dropped.
- FSM IDLE: cmd_ready=1. On cmd_valid, latch addr and beats into next_addr and issue_rem; set deliver_rem=beats.
  - beats==0: pulse done next cycle, stay IDLE, no read issued.
  - otherwise go to ISSUE and set busy=1.
- FSM ISSUE: compute blen=min(issue_rem, MAX_BURST) and free = FIFO_DEPTH - occupancy - outstanding.
  - If free>=blen, assert read with address=next_addr and burstcount=blen.
  - Hold read, address and burstcount stable while waitrequest=1.
  - A burst is accepted in the cycle read=1 and waitrequest=0. Then: outstanding+=blen, issue_rem-=blen, next_addr += blen*(SDRAM_DATA_W/8) with modular wrap at 2^SDRAM_ADDR_W.
  - read may be asserted again the very next cycle; multiple bursts may be outstanding.
  - When issue_rem reaches 0, go to DRAIN with read=0.
- FSM DRAIN: wait until deliver_rem==0, then go to IDLE, pulse done for exactly one cycle and drop busy in the same cycle.
- Data path: each readdatavalid pushes readdata into the FIFO and decrements outstanding. The credit scheme guarantees the push never overflows; overflow is an assertion failure.
- Output: out_valid = FIFO non-empty; out_data = FIFO head; out_last = (deliver_rem==1) && out_valid.
  - Pop when out_valid && out_ready, and decrement deliver_rem.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - Read latency from FIFO write to out_valid: 1 cycle.
- Simultaneous events in one cycle (burst accept, readdatavalid, pop) update the credit counters correctly. The credit uses registered occupancy and outstanding, so it is conservative.
- Readdata order is preserved; no reordering.

Test Plan:
- Single short command: addr=0x1000, beats=4, waitrequest=0, out_ready=1 → one burst (address 0x1000, burstcount 4); 4 beats out in order; out_last on beat 4; done pulses once.
- Burst splitting: beats=70, MAX_BURST=32 → bursts of 32, 32 and 6 at addresses base, base+0x200, base+0x400; 70 beats out.
- Backpressure: beats=200, out_ready=0 → at most 64 beats in flight or buffered; read deasserts; no FIFO overflow. Releasing out_ready completes all 200 beats.
- Waitrequest stall: hold waitrequest=1 for 5 cycles on burst 2 → address and burstcount stay stable; accepted on the 6th cycle.
- Zero length: beats=0 → no read asserted; done pulses the cycle after acceptance; busy stays 0.
- Reset mid-fetch: assert rst with 20 beats outstanding → all outputs return to reset values; late readdatavalid beats are dropped; a new command then runs cleanly.
